// File: rtl/clk_period_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_period_monitor_if
// Description : Signal bundle between the clock-period monitor and its
//               consumers: the monitored clock in, tick/period/status out.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_period_monitor_if #(
   parameter int CNT_W = 8
);

   // Monitored divided clock, asynchronous to clk_in
   logic             clk_mon;

   // One-cycle pulse per synchronized rising edge of clk_mon
   logic             tick;

   // Last measured period and its one-cycle update strobe
   logic [CNT_W-1:0] period;
   logic             period_valid;

   // Range result of the current period, valid alongside period_valid
   logic             in_range;

   // Lock / fault status levels
   logic             locked;
   logic             fault;

   // The monitor drives the results and consumes the monitored clock
   modport master (
      input  clk_mon,
      output tick,
      output period,
      output period_valid,
      output in_range,
      output locked,
      output fault
   );

   // The consumer side (clock source plus status readers)
   modport slave (
      output clk_mon,
      input  tick,
      input  period,
      input  period_valid,
      input  in_range,
      input  locked,
      input  fault
   );

endinterface
`default_nettype wire

// File: rtl/clk_period_monitor.sv
`default_nettype none
// ============================================================================
// Module      : clk_period_monitor
// Description : Synchronizes a slow asynchronous clock (clk_mon) into the
//               clk_in domain, emits a tick per rising edge, measures each
//               period in clk_in cycles and tracks lock / fault status.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_period_monitor #(
   parameter int EXP_PERIOD = 26,   // expected period in clk_in cycles
   parameter int TOL        = 1,    // allowed deviation from EXP_PERIOD
   parameter int LOCK_CNT   = 4,    // consecutive good periods to lock
   parameter int TIMEOUT    = 108,  // edge-free gap that counts as a fault
   parameter int CNT_W      = 8     // counter width, 2**CNT_W > TIMEOUT
) (
   input wire                   clk_in,
   input wire                   rst_n,
   clk_period_monitor_if.master mon
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam int GOOD_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

   // The counter saturates here; the last measurable value is TIMEOUT-1
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT - 1);
   // Counter value in which an edge-free cycle declares a timeout
   localparam logic [CNT_W-1:0]  CNT_TO    = CNT_W'(TIMEOUT - 2);
   // Inclusive acceptance window for a measured period
   localparam logic [CNT_W-1:0]  RANGE_LO  = CNT_W'(EXP_PERIOD - TOL);
   localparam logic [CNT_W-1:0]  RANGE_HI  = CNT_W'(EXP_PERIOD + TOL);
   localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);
   localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACQ   = 2'd1,
      ST_LOCK  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   // -------------------------------------------------------------------------
   // Signals
   // -------------------------------------------------------------------------
   logic              s1;            // first synchronizer stage
   logic              s2;            // second synchronizer stage
   logic              s3;            // history of s2 for edge detection
   logic              tick_w;        // rising edge seen this cycle

   logic [CNT_W-1:0]  cnt;           // cycles since the last tick cycle
   logic [CNT_W-1:0]  meas;          // period ending with this tick
   logic              need_first;    // next tick only re-arms the counter

   logic              meas_evt;      // a valid measurement completes now
   logic              meas_in_range; // that measurement is inside the window
   logic              timeout_evt;   // edge-free gap reached TIMEOUT

   logic [CNT_W-1:0]  period_r;
   logic              period_valid_r;
   logic              in_range_r;

   state_t            state;
   state_t            state_nxt;
   logic [GOOD_W-1:0] good_cnt;
   logic [GOOD_W-1:0] good_nxt;
   logic [GOOD_W-1:0] good_inc;

   // -------------------------------------------------------------------------
   // Synchronizer and rising-edge detector
   // -------------------------------------------------------------------------

   // Two-flop synchronizer followed by a history flop for edge detection
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= mon.clk_mon;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign tick_w = s2 & ~s3;

   // -------------------------------------------------------------------------
   // Period counter and event decode
   // -------------------------------------------------------------------------

   // cnt+1 equals the number of clk_in cycles between consecutive ticks
   assign meas          = cnt + CNT_W'(1);
   assign meas_in_range = (meas >= RANGE_LO) && (meas <= RANGE_HI);
   assign meas_evt      = tick_w & ~need_first;

   // A tick in the same cycle always suppresses the timeout. Because cnt
   // saturates one step later, the timeout fires only once per gap.
   assign timeout_evt   = ~tick_w && (cnt == CNT_TO);

   // Free-running gap counter, restarted by every tick and saturating
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (tick_w) begin
         cnt <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // After reset or a timeout the next edge only starts a fresh measurement
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         need_first <= 1'b1;
      end else if (timeout_evt) begin
         need_first <= 1'b1;
      end else if (tick_w) begin
         need_first <= 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Measurement outputs
   // -------------------------------------------------------------------------

   // Capture the measured period and its range verdict one cycle after tick
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         period_r       <= '0;
         period_valid_r <= 1'b0;
         in_range_r     <= 1'b0;
      end else begin
         period_valid_r <= meas_evt;
         if (meas_evt) begin
            period_r   <= meas;
            in_range_r <= meas_in_range;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Lock / fault state machine
   // -------------------------------------------------------------------------

   assign good_inc = good_cnt + GOOD_ONE;

   // State and good-period counter registers
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         good_cnt <= '0;
      end else begin
         state    <= state_nxt;
         good_cnt <= good_nxt;
      end
   end

   // Next-state logic; a timeout overrides every other transition
   always_comb begin
      state_nxt = state;
      good_nxt  = good_cnt;
      if (timeout_evt) begin
         state_nxt = ST_FAULT;
      end else begin
         case (state)
            ST_IDLE: begin
               // The first edge after reset is only an anchor point
               if (tick_w) begin
                  state_nxt = ST_ACQ;
                  good_nxt  = '0;
               end
            end
            ST_ACQ: begin
               if (meas_evt) begin
                  if (meas_in_range) begin
                     good_nxt = good_inc;
                     if (good_inc == GOOD_LOCK) begin
                        state_nxt = ST_LOCK;
                     end
                  end else begin
                     // Lock needs an unbroken run of good periods
                     good_nxt = '0;
                  end
               end
            end
            ST_LOCK: begin
               if (meas_evt && !meas_in_range) begin
                  state_nxt = ST_FAULT;
               end
            end
            ST_FAULT: begin
               // The recovering period already counts toward the next lock
               if (meas_evt && meas_in_range) begin
                  state_nxt = ST_ACQ;
                  good_nxt  = GOOD_ONE;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               good_nxt  = '0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Output mapping
   // -------------------------------------------------------------------------
   assign mon.tick         = tick_w;
   assign mon.period       = period_r;
   assign mon.period_valid = period_valid_r;
   assign mon.in_range     = in_range_r;
   assign mon.locked       = (state == ST_LOCK);
   assign mon.fault        = (state == ST_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_clk_period_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_period_monitor
// Description : Directed-plus-random bench for clk_period_monitor. clk_mon
//               is generated as a sequence of periods; a timestamp-based
//               reference model predicts tick, period and status per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_period_monitor;

   localparam int CNT_W = 8;
   localparam int EXP   = 26;
   localparam int TOL   = 1;
   localparam int LOCKN = 4;
   localparam int TMO   = 108;

   localparam int M_IDLE  = 0;
   localparam int M_ACQ   = 1;
   localparam int M_LOCK  = 2;
   localparam int M_FAULT = 3;

   logic clk_in = 1'b0;
   logic rst_n  = 1'b1;

   clk_period_monitor_if #(.CNT_W(CNT_W)) bus ();

   clk_period_monitor #(
      .EXP_PERIOD (EXP),
      .TOL        (TOL),
      .LOCK_CNT   (LOCKN),
      .TIMEOUT    (TMO),
      .CNT_W      (CNT_W)
   ) dut (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .mon    (bus.master)
   );

   always #5 clk_in = ~clk_in;

   // Scoreboard counters
   int tests = 0;
   int fails = 0;

   // Reference model: cycle index, timestamp of the last tick, status
   int cyc       = 0;
   int last_tick = 0;
   int mode      = M_IDLE;
   int good      = 0;
   bit need_first = 1'b1;
   bit e_pv      = 1'b0;
   bit e_inr     = 1'b0;
   int e_period  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clk_in cycle: drive clk_mon, compare outputs, then advance the model
   task automatic step(input logic mon_val, input bit exp_tick);
      int m;
      bit inr;
      @(posedge clk_in);
      cyc++;
      #($urandom_range(1, 4));
      bus.clk_mon = mon_val;
      @(negedge clk_in);
      check("tick",         bus.tick,         exp_tick);
      check("period_valid", bus.period_valid, e_pv);
      check("period",       bus.period,       e_period);
      if (e_pv) check("in_range", bus.in_range, e_inr);
      check("locked",       bus.locked,       mode == M_LOCK);
      check("fault",        bus.fault,        mode == M_FAULT);

      if (exp_tick) begin
         if (need_first) begin
            need_first = 1'b0;
            e_pv       = 1'b0;
            if (mode == M_IDLE) begin
               mode = M_ACQ;
               good = 0;
            end
         end else begin
            m        = cyc - last_tick;
            inr      = (m >= EXP - TOL) && (m <= EXP + TOL);
            e_pv     = 1'b1;
            e_period = m;
            e_inr    = inr;
            case (mode)
               M_ACQ: begin
                  if (inr) begin
                     good++;
                     if (good == LOCKN) mode = M_LOCK;
                  end else begin
                     good = 0;
                  end
               end
               M_LOCK:  if (!inr) mode = M_FAULT;
               M_FAULT: if (inr) begin mode = M_ACQ; good = 1; end
               default: ;
            endcase
         end
         last_tick = cyc;
      end else begin
         e_pv = 1'b0;
         if (cyc - last_tick == TMO - 1) begin
            mode       = M_FAULT;
            need_first = 1'b1;
         end
      end
   endtask

   // One full clk_mon period of p cycles with a random high time
   task automatic mon_cycle(input int p);
      int h;
      h = $urandom_range(2, p - 2);
      for (int i = 0; i < p; i++) step(i < h, i == 2);
   endtask

   task automatic hold_low(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   // Asynchronous reset placed between clock edges
   task automatic do_reset();
      #($urandom_range(1, 3));
      rst_n       = 1'b0;
      bus.clk_mon = 1'b0;
      #1;
      check("rst_tick",         bus.tick,         0);
      check("rst_period",       bus.period,       0);
      check("rst_period_valid", bus.period_valid, 0);
      check("rst_in_range",     bus.in_range,     0);
      check("rst_locked",       bus.locked,       0);
      check("rst_fault",        bus.fault,        0);
      repeat (2) @(posedge clk_in);
      #3 rst_n = 1'b1;
      mode       = M_IDLE;
      good       = 0;
      need_first = 1'b1;
      e_pv       = 1'b0;
      e_inr      = 1'b0;
      e_period   = 0;
      last_tick  = cyc - 1;
   endtask

   initial begin
      bus.clk_mon = 1'b0;
      do_reset();

      // Lock from reset
      repeat (6) mon_cycle(26);

      // Range boundaries
      mon_cycle(25); mon_cycle(27); mon_cycle(24); mon_cycle(28);
      repeat (4) mon_cycle(26);

      // Fault and relock
      mon_cycle(30);
      repeat (5) mon_cycle(26);

      // Acquire run broken after three good periods
      mon_cycle(30);
      repeat (3) mon_cycle(26);
      mon_cycle(20);
      repeat (5) mon_cycle(26);

      // Stuck clock, then recovery
      hold_low(150);
      repeat (3) mon_cycle(26);

      // Longest measurable period versus timeout on the same cycle
      mon_cycle(107);
      mon_cycle(108);
      repeat (6) mon_cycle(26);

      // Random periods around the window
      repeat (16) mon_cycle($urandom_range(22, 30));

      // Bring into ACQ, then reset mid-operation
      mon_cycle(40);
      repeat (3) mon_cycle(26);
      do_reset();
      repeat (6) mon_cycle(26);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/clk_period_monitor.md
# clk_period_monitor

Clock-period monitor that runs on clk_in and watches a slow, asynchronous divided clock, clk_mon, such as a divider output or an external reference. It does four things:
- synchronizes clk_mon into the clk_in domain;
- emits a one-cycle tick on each rising edge;
- measures every period in clk_in cycles;
- reports lock or fault status for the divided clock it consumes.

It sits beside the clock dividers and feeds the LED sequencer enable and the status LEDs.

## Interface
- EXP_PERIOD, 26: expected clk_mon period in clk_in cycles.
- TOL, 1: allowed deviation; a period is in range when |period − EXP_PERIOD| ≤ TOL.
- LOCK_CNT, 4: number of consecutive in-range periods required to lock.
- TIMEOUT, 108: a gap of this many clk_in cycles without an edge is a fault.
- CNT_W, 8: counter and period width; 2^CNT_W must exceed TIMEOUT.

Ports:
- clk_in  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- clk_mon  input  1  monitored clock, asynchronous to clk_in.
- tick  output  1  one-cycle pulse per synchronized rising edge of clk_mon.
- period  output  CNT_W  last measured period, held between measurements.
- period_valid  output  1  one-cycle pulse when period updates.
- in_range  output  1  range result for the current period; meaningful only while period_valid = 1.
- locked  output  1  high while in state LOCK.
- fault  output  1  high while in state FAULT.

## Operation
Synchronizer and edge detect:
- clk_mon passes through two flops (s1, s2), then a history flop s3; all three reset to 0.
- tick = s2 & ~s3.

Counter cnt:
- Clears to 0 on the clock edge that ends a tick cycle.
- Otherwise increments every cycle and saturates at TIMEOUT−1.

Flag need_first:
- Set by reset and by timeout.
- While need_first = 1, a tick only clears need_first and restarts cnt. No measurement is made.

Measurement, on a tick with need_first = 0:
- Measured value is cnt+1, which equals the clk_in cycles between consecutive ticks.
- Maximum measurable value is TIMEOUT−1.

Timeout:
- Fires when cnt == TIMEOUT−2 and there is no tick in that cycle.
- Fires exactly once per gap, because cnt then saturates.
- Sets need_first and forces state FAULT from any state, including IDLE.

State machine, with good_cnt of width ≥ clog2(LOCK_CNT+1):
- IDLE (reset state):
  - first tick → ACQ, good_cnt = 0.
- ACQ:
  - in-range measurement → good_cnt+1; when good_cnt reaches LOCK_CNT → LOCK.
  - out-of-range measurement → good_cnt = 0, stay in ACQ.
- LOCK:
  - out-of-range measurement → FAULT.
  - in-range measurement → stay in LOCK.
- FAULT:
  - in-range measurement → ACQ, good_cnt = 1.
  - out-of-range measurement → stay in FAULT.
  - timeout → stay in FAULT.

Priority and edge cases:
- A tick and the timeout condition in the same cycle: the tick wins and no timeout fires.
- In-range test: unsigned comparison, (EXP_PERIOD−TOL) ≤ m ≤ (EXP_PERIOD+TOL), evaluated on the full CNT_W width.

## Timing
- Reset (asynchronous, immediate), including mid-operation:
  - all outputs = 0: tick, period, period_valid, in_range, locked, fault;
  - cnt = 0, good_cnt = 0, need_first = 1, state = IDLE.
- tick latency: tick is high during the cycle after the second clk_in edge that samples clk_mon = 1 (2–3 cycles after the clk_mon edge). Duration is exactly 1 cycle.
- Measurement outputs: period, in_range and period_valid are registered and appear the cycle after tick.
- Status on measurement: locked and fault change on the same edge as period_valid.
- Status on timeout: fault rises exactly TIMEOUT cycles after the last tick cycle, and locked falls on the same edge.
- Minimum clk_mon high and low time: 2 clk_in cycles. Faster input is not supported.

## Test plan
1. Lock from reset:
   - Stimulus: release reset; clk_mon period 26 cycles, 13 high / 13 low.
   - Required: first tick produces no period_valid; each later tick produces period_valid with period = 26 and in_range = 1; locked rises with the 4th period_valid; fault stays 0.
2. Range boundaries:
   - Stimulus: periods of 25, 27, 24 and 28 cycles.
   - Required: 25 and 27 give in_range = 1; 24 and 28 give in_range = 0.
3. Fault and relock:
   - Stimulus: while locked, apply one 30-cycle period, then 26-cycle periods.
   - Required: fault = 1 and locked = 0 with that period_valid; the first good period moves the state to ACQ; locked returns after 3 more good periods.
4. Acquire reset:
   - Stimulus: in ACQ with 3 good periods counted, apply a 20-cycle period, then 26-cycle periods.
   - Required: no lock; locked rises only after 4 further consecutive good periods.
5. Stuck clock:
   - Stimulus: while locked, hold clk_mon low.
   - Required: fault rises exactly 108 cycles after the last tick and does not pulse again; the next edge gives a tick with no period_valid; the following 26-cycle edge gives period_valid with period = 26.
6. Reset mid-operation:
   - Stimulus: assert rst_n low mid-ACQ, asynchronously to clk_in.
   - Required: all outputs go to 0 immediately; after release, behaviour matches scenario 1, with the first edge unmeasured.
